hazard_stall_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage 16-bit core.
- Drives the enable and flush controls of the PC, IFID, IDEX, EXMEM and MEMWB registers.
- Resolves four event classes in a fixed priority: data-memory stall, taken branch, load-use hazard and instruction-memory stall.
- Also drains the pipe on HALT and keeps a stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl_if.sv | 45 ++++
 rtl/hazard_stall_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall controller bundle.
// Pipeline status in, register enables and flushes out.
interface hazard_stall_ctrl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs;
  logic             id_rs_vld;
  logic [REG_W-1:0] id_rt;
  logic             id_rt_vld;
  logic             ex_memrd;
  logic [REG_W-1:0] ex_rd;
  logic             ex_rd_vld;
  logic             br_taken;
  logic             imem_busy;
  logic             dmem_busy;
  logic             halt_in;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rs_vld, id_rt, id_rt_vld,
    output ex_memrd, ex_rd, ex_rd_vld,
    output br_taken, imem_busy, dmem_busy, halt_in,
    input  pc_en, ifid_en, ifid_flush,
    input  idex_en, idex_flush, exmem_en, memwb_en,
    input  halted, stall_cnt
  );

  modport slave (
    input  id_rs, id_rs_vld, id_rt, id_rt_vld,
    input  ex_memrd, ex_rd, ex_rd_vld,
    input  br_taken, imem_busy, dmem_busy, halt_in,
    output pc_en, ifid_en, ifid_flush,
    output idex_en, idex_flush, exmem_en, memwb_en,
    output halted, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central sequencer for the 5-stage 16-bit pipe.
// Prioritises freezes, redirects, bubbles and HALT drain.
module hazard_stall_ctrl #(
  parameter int REG_W     = 3,
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input logic          clk,
  input logic          rst,
  hazard_stall_ctrl_if.slave bus
);

  localparam int DW = (DRAIN_CYC > 1) ?
                      $clog2(DRAIN_CYC) : 1;

  // {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem, memwb}
  localparam logic [6:0] C_RUN = 7'b1101011;
  localparam logic [6:0] C_FRZ = 7'b0000000;
  localparam logic [6:0] C_BR  = 7'b1111111;
  localparam logic [6:0] C_LU  = 7'b0001111;
  localparam logic [6:0] C_IW  = 7'b0111011;
  localparam logic [6:0] C_RST = 7'b0010100;

  typedef enum logic [1:0] {
    S_RUN,
    S_IWAIT,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_nstate;
  logic [DW-1:0]    r_dcnt;
  logic [DW-1:0]    w_ndcnt;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       w_ctl;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_lu;
  logic w_ev_dm;
  logic w_ev_br;
  logic w_ev_lu;
  logic w_ev_im;
  logic w_ev_ht;
  logic w_ev_no;

  // Load-use match against the EX load destination
  always_comb begin
    w_rs_hit = bus.id_rs_vld &&
               (bus.id_rs == bus.ex_rd);
    w_rt_hit = bus.id_rt_vld &&
               (bus.id_rt == bus.ex_rd);
    w_lu     = bus.ex_memrd && bus.ex_rd_vld &&
               (w_rs_hit || w_rt_hit);
  end

  // One-hot event decode in fixed priority order
  always_comb begin
    w_ev_dm = bus.dmem_busy;
    w_ev_br = !w_ev_dm && bus.br_taken;
    w_ev_lu = !w_ev_dm && !bus.br_taken && w_lu;
    w_ev_im = !w_ev_dm && !bus.br_taken &&
              !w_lu && bus.imem_busy;
    w_ev_ht = !w_ev_dm && !bus.br_taken &&
              !w_lu && !bus.imem_busy &&
              bus.halt_in;
    w_ev_no = !w_ev_dm && !bus.br_taken &&
              !w_lu && !bus.imem_busy &&
              !bus.halt_in;
  end

  // Next-state and pipeline control outputs
  always_comb begin
    w_ctl    = C_RUN;
    w_nstate = r_state;
    w_ndcnt  = r_dcnt;
    if (!rst) begin
      w_ctl = C_RST;
    end else begin
      unique case (r_state)
        S_RUN, S_IWAIT: begin
          unique case (1'b1)
            w_ev_dm: w_ctl = C_FRZ;
            w_ev_br: begin
              w_ctl    = C_BR;
              w_nstate = S_RUN;
            end
            w_ev_lu: begin
              w_ctl    = C_LU;
              w_nstate = bus.imem_busy ?
                         S_IWAIT : S_RUN;
            end
            w_ev_im: begin
              w_ctl    = C_IW;
              w_nstate = S_IWAIT;
            end
            w_ev_ht: begin
              w_ctl    = C_IW;
              w_nstate = S_DRAIN;
              w_ndcnt  = DW'(DRAIN_CYC - 1);
            end
            w_ev_no: begin
              w_ctl    = C_RUN;
              w_nstate = S_RUN;
            end
            default: w_ctl = C_RUN;
          endcase
        end
        S_DRAIN: begin
          if (bus.dmem_busy) begin
            w_ctl = C_FRZ;
          end else if (bus.br_taken) begin
            w_ctl    = C_BR;
            w_nstate = S_RUN;
            w_ndcnt  = '0;
          end else begin
            w_ctl = C_IW;
            if (r_dcnt == '0) begin
              w_nstate = S_HALT;
            end else begin
              w_ndcnt = r_dcnt - DW'(1);
            end
          end
        end
        S_HALT: w_ctl = C_FRZ;
        default: w_ctl = C_FRZ;
      endcase
    end
  end

  // State and drain counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_nstate;
      r_dcnt  <= w_ndcnt;
    end
  end

  // Saturating count of fetch-stalled cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!w_ctl[6] &&
                 (r_state != S_HALT) &&
                 !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.pc_en      = w_ctl[6];
  assign bus.ifid_en    = w_ctl[5];
  assign bus.ifid_flush = w_ctl[4];
  assign bus.idex_en    = w_ctl[3];
  assign bus.idex_flush = w_ctl[2];
  assign bus.exmem_en   = w_ctl[1];
  assign bus.memwb_en   = w_ctl[0];
  assign bus.halted     = (r_state == S_HALT);
  assign bus.stall_cnt  = r_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl.
// Main DUT plus a 4-bit counter copy for saturation.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_W(3), .CNT_W(16)) u_if ();
  hazard_stall_ctrl_if #(.REG_W(3), .CNT_W(4))  u_if4 ();

  hazard_stall_ctrl #(
    .REG_W(3), .CNT_W(16), .DRAIN_CYC(3)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(u_if)
  );

  hazard_stall_ctrl #(
    .REG_W(3), .CNT_W(4), .DRAIN_CYC(3)
  ) u_dut4 (
    .clk(clk), .rst(rst), .bus(u_if4)
  );

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  // {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem, memwb}
  wire [6:0] obs = {
    u_if.pc_en, u_if.ifid_en, u_if.ifid_flush,
    u_if.idex_en, u_if.idex_flush,
    u_if.exmem_en, u_if.memwb_en
  };

  task automatic idle();
    u_if.id_rs = '0; u_if.id_rs_vld = 0;
    u_if.id_rt = '0; u_if.id_rt_vld = 0;
    u_if.ex_memrd = 0; u_if.ex_rd = '0;
    u_if.ex_rd_vld = 0; u_if.br_taken = 0;
    u_if.imem_busy = 0; u_if.dmem_busy = 0;
    u_if.halt_in = 0;
    u_if4.id_rs = '0; u_if4.id_rs_vld = 0;
    u_if4.id_rt = '0; u_if4.id_rt_vld = 0;
    u_if4.ex_memrd = 0; u_if4.ex_rd = '0;
    u_if4.ex_rd_vld = 0; u_if4.br_taken = 0;
    u_if4.imem_busy = 0; u_if4.dmem_busy = 0;
    u_if4.halt_in = 0;
  endtask

  task automatic set_lu(input logic [2:0] r);
    u_if.ex_memrd = 1; u_if.ex_rd = r;
    u_if.ex_rd_vld = 1;
    u_if.id_rt = r; u_if.id_rt_vld = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    idle();
    #1;
    checks++;
    if (obs !== 7'b0010100) begin
      errors++;
      $display("FAIL rst_init obs=%b exp=%b", obs, 7'b0010100);
    end
    @(negedge clk); #2 rst = 1;
    @(negedge clk);
    u_if.imem_busy = 1;
    #1;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (u_if.stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL pre_rst_cnt got=%0d exp=1", u_if.stall_cnt);
    end
    u_if.dmem_busy = 1;
    #1;
    checks++;
    if (obs !== 7'b0000000) begin
      errors++;
      $display("FAIL pre_rst_frz obs=%b exp=%b", obs, 7'b0);
    end
    #1 rst = 0;
    #1;
    checks++;
    if (obs !== 7'b0010100 || u_if.stall_cnt !== 16'd0 ||
        u_if.halted !== 1'b0) begin
      errors++;
      $display("FAIL rst_async obs=%b cnt=%0d h=%b exp=%b/0/0",
               obs, u_if.stall_cnt, u_if.halted, 7'b0010100);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== 7'b0010100) begin
      errors++;
      $display("FAIL rst_hold obs=%b exp=%b", obs, 7'b0010100);
    end
    @(negedge clk);
    rst = 1;
    u_if.dmem_busy = 0;
    #1;
    checks++;
    if (obs !== 7'b1101011 || u_if.stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_rel obs=%b cnt=%0d exp=%b/0",
               obs, u_if.stall_cnt, 7'b1101011);
    end
    exp_cnt = 0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_lu(3'd3);
    #1;
    checks++;
    if (obs !== 7'b0001111) begin
      errors++;
      $display("FAIL lu_rt obs=%b exp=%b", obs, 7'b0001111);
    end
    exp_cnt++;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (obs !== 7'b1101011 || u_if.stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL lu_one obs=%b cnt=%0d exp=%b/%0d",
               obs, u_if.stall_cnt, 7'b1101011, exp_cnt);
    end
    @(negedge clk);
    set_lu(3'd3);
    u_if.id_rt_vld = 0;
    #1;
    checks++;
    if (obs !== 7'b1101011) begin
      errors++;
      $display("FAIL lu_novld obs=%b exp=%b", obs, 7'b1101011);
    end
    @(negedge clk);
    set_lu(3'd5);
    u_if.id_rt = 3'd2;
    u_if.id_rs = 3'd5; u_if.id_rs_vld = 1;
    #1;
    checks++;
    if (obs !== 7'b0001111) begin
      errors++;
      $display("FAIL lu_rs obs=%b exp=%b", obs, 7'b0001111);
    end
    exp_cnt++;
    @(negedge clk);
    idle();
    set_lu(3'd4);
    u_if.ex_rd_vld = 0;
    #1;
    checks++;
    if (obs !== 7'b1101011) begin
      errors++;
      $display("FAIL lu_nowr obs=%b exp=%b", obs, 7'b1101011);
    end
    @(negedge clk);
    idle();
    set_lu(3'd4);
    u_if.ex_memrd = 0;
    #1;
    checks++;
    if (obs !== 7'b1101011 || u_if.stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL lu_noload obs=%b cnt=%0d exp=%b/%0d",
               obs, u_if.stall_cnt, 7'b1101011, exp_cnt);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    idle();
    set_lu(3'd1);
    u_if.br_taken = 1;
    #1;
    checks++;
    if (obs !== 7'b1111111) begin
      errors++;
      $display("FAIL br_lu obs=%b exp=%b", obs, 7'b1111111);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      u_if.dmem_busy = 1;
      #1;
      checks++;
      if (obs !== 7'b0000000) begin
        errors++;
        $display("FAIL br_frz%0d obs=%b exp=%b", i, obs, 7'b0);
      end
      exp_cnt++;
    end
    @(negedge clk);
    u_if.dmem_busy = 0;
    #1;
    checks++;
    if (obs !== 7'b1111111 || u_if.stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL br_after obs=%b cnt=%0d exp=%b/%0d",
               obs, u_if.stall_cnt, 7'b1111111, exp_cnt);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (obs !== 7'b1101011 || u_if.stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL br_idle obs=%b cnt=%0d exp=%b/%0d",
               obs, u_if.stall_cnt, 7'b1101011, exp_cnt);
    end
  endtask

  task automatic test_imem();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      u_if.imem_busy = 1;
      #1;
      checks++;
      if (obs !== 7'b0111011) begin
        errors++;
        $display("FAIL iw%0d obs=%b exp=%b", i, obs, 7'b0111011);
      end
      exp_cnt++;
    end
    @(negedge clk);
    u_if.imem_busy = 0;
    #1;
    checks++;
    if (obs !== 7'b1101011 || u_if.stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL iw_done obs=%b cnt=%0d exp=%b/%0d",
               obs, u_if.stall_cnt, 7'b1101011, exp_cnt);
    end
    @(negedge clk);
    set_lu(3'd6);
    u_if.imem_busy = 1;
    #1;
    checks++;
    if (obs !== 7'b0001111) begin
      errors++;
      $display("FAIL lu_iw obs=%b exp=%b", obs, 7'b0001111);
    end
    exp_cnt++;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (obs !== 7'b1101011 || u_if.stall_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL lu_iw_end obs=%b cnt=%0d exp=%b/%0d",
               obs, u_if.stall_cnt, 7'b1101011, exp_cnt);
    end
  endtask

  task automatic test_halt_abort();
    @(negedge clk);
    u_if.halt_in = 1;
    #1;
    checks++;
    if (obs !== 7'b0111011 || u_if.halted !== 1'b0) begin
      errors++;
      $display("FAIL ha_dec obs=%b h=%b exp=%b/0",
               obs, u_if.halted, 7'b0111011);
    end
    exp_cnt++;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (obs !== 7'b0111011) begin
      errors++;
      $display("FAIL ha_d1 obs=%b exp=%b", obs, 7'b0111011);
    end
    exp_cnt++;
    @(negedge clk);
    u_if.br_taken = 1;
    #1;
    checks++;
    if (obs !== 7'b1111111) begin
      errors++;
      $display("FAIL ha_br obs=%b exp=%b", obs, 7'b1111111);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (obs !== 7'b1101011 || u_if.halted !== 1'b0 ||
          u_if.stall_cnt !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL ha_run%0d obs=%b h=%b cnt=%0d exp=%b/0/%0d",
                 i, obs, u_if.halted, u_if.stall_cnt,
                 7'b1101011, exp_cnt);
      end
    end
  endtask

  task automatic test_halt_drain();
    @(negedge clk);
    set_lu(3'd2);
    u_if.halt_in = 1;
    #1;
    checks++;
    if (obs !== 7'b0001111) begin
      errors++;
      $display("FAIL hd_lu obs=%b exp=%b", obs, 7'b0001111);
    end
    exp_cnt++;
    @(negedge clk);
    idle();
    u_if.halt_in = 1;
    #1;
    checks++;
    if (obs !== 7'b0111011) begin
      errors++;
      $display("FAIL hd_dec obs=%b exp=%b", obs, 7'b0111011);
    end
    exp_cnt++;
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (obs !== 7'b0111011 || u_if.halted !== 1'b0) begin
      errors++;
      $display("FAIL hd_d1 obs=%b h=%b exp=%b/0",
               obs, u_if.halted, 7'b0111011);
    end
    exp_cnt++;
    @(negedge clk);
    u_if.dmem_busy = 1;
    #1;
    checks++;
    if (obs !== 7'b0000000) begin
      errors++;
      $display("FAIL hd_frz obs=%b exp=%b", obs, 7'b0);
    end
    exp_cnt++;
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk);
      idle();
      #1;
      checks++;
      if (obs !== 7'b0111011 || u_if.halted !== 1'b0) begin
        errors++;
        $display("FAIL hd_d%0d obs=%b h=%b exp=%b/0",
                 i, obs, u_if.halted, 7'b0111011);
      end
      exp_cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        set_lu(3'd7);
        u_if.br_taken = 1; u_if.imem_busy = 1;
        u_if.halt_in = 1;
      end
      #1;
      checks++;
      if (obs !== 7'b0000000 || u_if.halted !== 1'b1 ||
          u_if.stall_cnt !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL hd_halt%0d obs=%b h=%b cnt=%0d exp=%b/1/%0d",
                 i, obs, u_if.halted, u_if.stall_cnt,
                 7'b0, exp_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    int e4;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      u_if4.imem_busy = 1;
      #1;
      e4 = (i < 15) ? i : 15;
      checks++;
      if (u_if4.stall_cnt !== 4'(e4) || u_if4.pc_en !== 1'b0) begin
        errors++;
        $display("FAIL sat%0d cnt=%0d pc=%b exp=%0d/0",
                 i, u_if4.stall_cnt, u_if4.pc_en, e4);
      end
    end
    @(negedge clk);
    u_if4.imem_busy = 0;
    #1;
    checks++;
    if (u_if4.stall_cnt !== 4'd15 || u_if4.pc_en !== 1'b1) begin
      errors++;
      $display("FAIL sat_end cnt=%0d pc=%b exp=15/1",
               u_if4.stall_cnt, u_if4.pc_en);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_imem();
    test_halt_abort();
    test_halt_drain();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
